pipe_mips32_core: RTL and testbench

- Five-stage in-order pipelined MIPS32-subset processor (IF, ID, EX, MEM, WB) with internal program memory, data memory and register file.
- Top-level compute core, driven only by clock and reset.
- Resolves data hazards by forwarding plus a one-cycle load-use interlock; resolves control hazards by flushing on taken branches.
- Benches preload and inspect state through hierarchical references to the internal arrays.

---
 rtl/pipe_mips32_core.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_mips32_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_mips32_core.sv
// rtl/pipe_mips32_core.sv - five-stage MIPS32-subset core with forwarding, load-use interlock and branch flush
module pipe_mips32_core #(
  parameter int PROG_DEPTH = 1024,
  parameter int DATA_DEPTH = 1024
) (
  input logic clk,
  input logic reset
);

  localparam int PAW = $clog2(PROG_DEPTH);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam logic [PAW-1:0] PC_ONE = PAW'(1);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  logic [31:0] Reg     [0:31];
  logic [31:0] ProgMem [0:PROG_DEPTH-1];
  logic [31:0] DataMem [0:DATA_DEPTH-1];

  logic           halted;
  logic           fetch_stopped;
  logic [PAW-1:0] pc;

  logic           ifid_valid;
  logic [31:0]    ifid_ir;
  logic [PAW-1:0] ifid_pc;

  logic           idex_valid;
  logic [5:0]     idex_op;
  logic [PAW-1:0] idex_pc;
  logic [4:0]     idex_rs, idex_rt, idex_dest;
  logic           idex_regwrite;
  logic [31:0]    idex_a, idex_b, idex_imm;

  logic           exmem_regwrite, exmem_load, exmem_store, exmem_halt;
  logic [4:0]     exmem_dest;
  logic [31:0]    exmem_alu, exmem_sdata;

  logic           memwb_regwrite, memwb_halt;
  logic [4:0]     memwb_dest;
  logic [31:0]    memwb_result;

  logic [5:0]     id_op;
  logic [4:0]     id_rs, id_rt, id_rd, id_dest;
  logic [31:0]    id_imm, id_a, id_b;
  logic           id_is_r, id_is_imm, id_reads_rs, id_reads_rt, id_regwrite;

  logic [31:0]    fwd_a, fwd_b, ex_result;
  logic           br_taken;
  logic [PAW-1:0] br_target;
  logic           stall, flush, hlt_in_id, wb_we;
  logic [DAW-1:0] mem_addr;
  logic [31:0]    mem_result;

  assign wb_we = memwb_regwrite && (memwb_dest != 5'd0) && !halted;

  // Decode and register read; WB bypass makes the file write-before-read
  always_comb begin
    id_op       = ifid_ir[31:26];
    id_rs       = ifid_ir[25:21];
    id_rt       = ifid_ir[20:16];
    id_rd       = ifid_ir[15:11];
    id_imm      = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
    id_is_r     = (id_op <= OP_MUL);
    id_is_imm   = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
    id_reads_rs = id_is_r || id_is_imm || (id_op == OP_LW) || (id_op == OP_SW) ||
                  (id_op == OP_BEQZ) || (id_op == OP_BNEQZ);
    id_reads_rt = id_is_r || (id_op == OP_SW);
    id_regwrite = ifid_valid && (id_is_r || id_is_imm || (id_op == OP_LW));
    id_dest     = id_is_r ? id_rd : id_rt;
    if (id_rs == 5'd0)                         id_a = 32'd0;
    else if (wb_we && (memwb_dest == id_rs))   id_a = memwb_result;
    else                                       id_a = Reg[id_rs];
    if (id_rt == 5'd0)                         id_b = 32'd0;
    else if (wb_we && (memwb_dest == id_rt))   id_b = memwb_result;
    else                                       id_b = Reg[id_rt];
  end

  // EX/MEM cannot forward a load: its ALU value is the address, the interlock covers that case
  always_comb begin
    if (exmem_regwrite && !exmem_load && (exmem_dest != 5'd0) && (exmem_dest == idex_rs))
      fwd_a = exmem_alu;
    else if (memwb_regwrite && (memwb_dest != 5'd0) && (memwb_dest == idex_rs))
      fwd_a = memwb_result;
    else
      fwd_a = idex_a;
    if (exmem_regwrite && !exmem_load && (exmem_dest != 5'd0) && (exmem_dest == idex_rt))
      fwd_b = exmem_alu;
    else if (memwb_regwrite && (memwb_dest != 5'd0) && (memwb_dest == idex_rt))
      fwd_b = memwb_result;
    else
      fwd_b = idex_b;
  end

  always_comb begin
    ex_result = 32'd0;
    case (idex_op)
      OP_ADD:                 ex_result = fwd_a + fwd_b;
      OP_SUB:                 ex_result = fwd_a - fwd_b;
      OP_AND:                 ex_result = fwd_a & fwd_b;
      OP_OR:                  ex_result = fwd_a | fwd_b;
      OP_SLT:                 ex_result = ($signed(fwd_a) < $signed(fwd_b)) ? 32'd1 : 32'd0;
      OP_MUL:                 ex_result = fwd_a * fwd_b;
      OP_ADDI, OP_LW, OP_SW:  ex_result = fwd_a + idex_imm;
      OP_SUBI:                ex_result = fwd_a - idex_imm;
      OP_SLTI:                ex_result = ($signed(fwd_a) < $signed(idex_imm)) ? 32'd1 : 32'd0;
      default:                ex_result = 32'd0;
    endcase
    br_taken  = idex_valid && (((idex_op == OP_BEQZ) && (fwd_a == 32'd0)) ||
                               ((idex_op == OP_BNEQZ) && (fwd_a != 32'd0)));
    br_target = idex_pc + PC_ONE + idex_imm[PAW-1:0];
  end

  assign flush     = br_taken;
  assign stall     = ifid_valid && idex_valid && (idex_op == OP_LW) &&
                     ((id_reads_rs && (id_rs == idex_rt)) || (id_reads_rt && (id_rt == idex_rt)));
  assign hlt_in_id = ifid_valid && (id_op == OP_HLT) && !flush;

  assign mem_addr   = exmem_alu[DAW-1:0];
  assign mem_result = exmem_load ? DataMem[mem_addr] : exmem_alu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc             <= '0;
      halted         <= 1'b0;
      fetch_stopped  <= 1'b0;
      ifid_valid     <= 1'b0;
      ifid_ir        <= 32'd0;
      ifid_pc        <= '0;
      idex_valid     <= 1'b0;
      idex_op        <= 6'd0;
      idex_pc        <= '0;
      idex_rs        <= 5'd0;
      idex_rt        <= 5'd0;
      idex_dest      <= 5'd0;
      idex_regwrite  <= 1'b0;
      idex_a         <= 32'd0;
      idex_b         <= 32'd0;
      idex_imm       <= 32'd0;
      exmem_regwrite <= 1'b0;
      exmem_load     <= 1'b0;
      exmem_store    <= 1'b0;
      exmem_halt     <= 1'b0;
      exmem_dest     <= 5'd0;
      exmem_alu      <= 32'd0;
      exmem_sdata    <= 32'd0;
      memwb_regwrite <= 1'b0;
      memwb_halt     <= 1'b0;
      memwb_dest     <= 5'd0;
      memwb_result   <= 32'd0;
    end else begin
      // Flush outranks the interlock; after HLT is decoded only bubbles enter IF/ID
      if (flush) begin
        pc         <= br_target;
        ifid_valid <= 1'b0;
      end else if (stall) begin
        pc         <= pc;
      end else if (fetch_stopped || hlt_in_id) begin
        ifid_valid <= 1'b0;
      end else begin
        ifid_valid <= 1'b1;
        ifid_ir    <= ProgMem[pc];
        ifid_pc    <= pc;
        pc         <= pc + PC_ONE;
      end
      if (hlt_in_id)
        fetch_stopped <= 1'b1;

      if (flush || stall) begin
        idex_valid    <= 1'b0;
        idex_op       <= 6'd0;
        idex_regwrite <= 1'b0;
      end else begin
        idex_valid    <= ifid_valid;
        idex_op       <= id_op;
        idex_regwrite <= id_regwrite;
      end
      idex_pc   <= ifid_pc;
      idex_rs   <= id_rs;
      idex_rt   <= id_rt;
      idex_dest <= id_dest;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= id_imm;

      exmem_regwrite <= idex_regwrite;
      exmem_load     <= idex_valid && (idex_op == OP_LW);
      exmem_store    <= idex_valid && (idex_op == OP_SW);
      exmem_halt     <= idex_valid && (idex_op == OP_HLT);
      exmem_dest     <= idex_dest;
      exmem_alu      <= ex_result;
      exmem_sdata    <= fwd_b;

      memwb_regwrite <= exmem_regwrite;
      memwb_halt     <= exmem_halt;
      memwb_dest     <= exmem_dest;
      memwb_result   <= mem_result;

      if (memwb_halt)
        halted <= 1'b1;
    end
  end

  // Architectural storage is deliberately outside reset so preloaded contents survive it
  always_ff @(posedge clk) begin
    if (wb_we)
      Reg[memwb_dest] <= memwb_result;
    if (exmem_store && !halted)
      DataMem[mem_addr] <= exmem_sdata;
  end

endmodule

// File: tb/tb_pipe_mips32_core.sv
// tb/tb_pipe_mips32_core.sv - directed self-checking bench for pipe_mips32_core
module tb_pipe_mips32_core;

  logic clk;
  logic reset;

  pipe_mips32_core dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];
  int   total  = 0;
  int   passed = 0;
  int   stalls, flushes, cyc;
  int   ex_pcs [$];
  int   exp_pcs [7] = '{0, 1, 2, 3, 4, 10, 11};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_prog(input string name, input int max_cyc);
    stalls  = 0;
    flushes = 0;
    cyc     = 0;
    ex_pcs.delete();
    @(negedge clk);
    reset = 1'b1;
    while (dut.halted !== 1'b1 && cyc < max_cyc) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (dut.stall) stalls++;
      if (dut.flush) flushes++;
      if (dut.idex_valid) ex_pcs.push_back(int'(dut.idex_pc));
    end
    check({name, "_halted"}, 32'(dut.halted), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"add",   32'h00221800, 32'd7,        32'd5,        32'd12};
    vecs[1]  = '{"sub",   32'h04221800, 32'd5,        32'd7,        32'hFFFFFFFE};
    vecs[2]  = '{"and",   32'h08221800, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200};
    vecs[3]  = '{"or",    32'h0C221800, 32'hF0000001, 32'h000000F0, 32'hF00000F1};
    vecs[4]  = '{"slt_t", 32'h10221800, 32'hFFFFFFFF, 32'd1,        32'd1};
    vecs[5]  = '{"slt_f", 32'h10221800, 32'd5,        32'hFFFFFFFE, 32'd0};
    vecs[6]  = '{"mul",   32'h14221800, 32'h00010001, 32'h00010003, 32'h00040003};
    vecs[7]  = '{"addi",  32'h2823FFFD, 32'd10,       32'd0,        32'd7};
    vecs[8]  = '{"subi",  32'h2C230005, 32'd3,        32'd0,        32'hFFFFFFFE};
    vecs[9]  = '{"slti",  32'h3023FFFF, 32'hFFFFFFFE, 32'd0,        32'd1};
    vecs[10] = '{"nop",   32'h50221800, 32'd1,        32'd2,        32'hDEADBEEF};

    reset = 1'b0;
    @(negedge clk);
    check("rst_pc",     32'(dut.pc),         32'd0);
    check("rst_halted", 32'(dut.halted),     32'd0);
    check("rst_ifid",   32'(dut.ifid_valid), 32'd0);
    check("rst_idex",   32'(dut.idex_valid), 32'd0);

    for (int i = 0; i < 11; i++) begin
      hold_reset();
      dut.Reg[0]     = 32'd0;
      dut.Reg[1]     = vecs[i].a;
      dut.Reg[2]     = vecs[i].b;
      dut.Reg[3]     = 32'hDEADBEEF;
      dut.ProgMem[0] = vecs[i].instr;
      dut.ProgMem[1] = 32'hFC000000;
      run_prog(vecs[i].name, 30);
      check(vecs[i].name, dut.Reg[3], vecs[i].exp);
    end

    // Back-to-back forwarding, not-taken branch on R0, write to R0
    hold_reset();
    for (int k = 0; k < 8; k++) dut.Reg[k] = 32'd0;
    dut.ProgMem[0] = 32'h28010005;
    dut.ProgMem[1] = 32'h00211000;
    dut.ProgMem[2] = 32'h04411800;
    dut.ProgMem[3] = 32'h34000003;
    dut.ProgMem[4] = 32'h28000007;
    dut.ProgMem[5] = 32'h28060001;
    dut.ProgMem[6] = 32'h10623800;
    dut.ProgMem[7] = 32'hFC000000;
    run_prog("fwd", 30);
    check("fwd_r1",      dut.Reg[1],  32'd5);
    check("fwd_r2",      dut.Reg[2],  32'd10);
    check("fwd_r3",      dut.Reg[3],  32'd5);
    check("fwd_r0",      dut.Reg[0],  32'd0);
    check("fwd_nt_r6",   dut.Reg[6],  32'd1);
    check("fwd_slt_r7",  dut.Reg[7],  32'd1);
    check("fwd_stalls",  32'(stalls), 32'd0);
    check("fwd_flushes", 32'(flushes), 32'd0);

    // Load-ALU, load-branch, store and halt
    hold_reset();
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    dut.DataMem[2]  = 32'd8;
    dut.DataMem[4]  = 32'd13;
    dut.DataMem[7]  = 32'd0;
    dut.DataMem[11] = 32'd0;
    dut.ProgMem[0]  = 32'h20410000;
    dut.ProgMem[1]  = 32'h20830000;
    dut.ProgMem[2]  = 32'h00232800;
    dut.ProgMem[3]  = 32'h216A0000;
    dut.ProgMem[4]  = 32'h39400005;
    for (int k = 0; k < 5; k++) dut.ProgMem[5+k] = 32'h28000063 | (32'(20 + k) << 16);
    dut.ProgMem[10] = 32'h24E50000;
    dut.ProgMem[11] = 32'hFC000000;
    run_prog("comb", 20);
    check("comb_r5",      dut.Reg[5],      32'd21);
    check("comb_r10",     dut.Reg[10],     32'd0);
    check("comb_dm7",     dut.DataMem[7],  32'd21);
    check("comb_stalls",  32'(stalls),     32'd2);
    check("comb_flushes", 32'(flushes),    32'd1);
    for (int k = 0; k < 5; k++) check("comb_skip", dut.Reg[20+k], 32'(20 + k));
    check("comb_ex_len", 32'(ex_pcs.size()), 32'd7);
    for (int k = 0; k < 7 && k < ex_pcs.size(); k++) check("comb_ex_pc", 32'(ex_pcs[k]), 32'(exp_pcs[k]));

    // Asynchronous reset while halted, then again mid-run
    #2 reset = 1'b0;
    #1;
    check("rst_h_pc",     32'(dut.pc),     32'd0);
    check("rst_h_halted", 32'(dut.halted), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_pc_moved", 32'(dut.pc != '0), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_pc",     32'(dut.pc),         32'd0);
    check("mid_ifid",   32'(dut.ifid_valid), 32'd0);
    check("mid_dm7",    dut.DataMem[7],      32'd21);
    check("mid_r5",     dut.Reg[5],          32'd21);
    check("mid_prog0",  dut.ProgMem[0],      32'h20410000);
    @(negedge clk);
    dut.DataMem[2] = 32'd30;
    run_prog("restart", 20);
    check("restart_r5",  dut.Reg[5],     32'd43);
    check("restart_dm7", dut.DataMem[7], 32'd43);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
